soc_mmio_bridge: RTL and testbench
==================================

# soc_mmio_bridge

Parametrised data-side bridge for the simulation SoC. It sits between the CPU data port and the data memory. It splits the address space into plain memory and a small MMIO window. The window holds a buffered console TX FIFO, a 64-bit cycle counter and a `tohost` halt/exit register. This lets test programs print, time themselves and terminate the simulation without bench-side peeking.

## Interface
Parameters:
- `XLEN`, 32, data/address width
- `MMIO_BASE`, 32'hFFFF_0000, base of the MMIO window; window size is 256 bytes, so `MMIO_BASE[7:0]` must be 0
- `TX_DEPTH`, 16, console FIFO depth; power of two, ≥2

Ports:
- `clk` in 1: single clock
- `reset` in 1: synchronous, active-high
- `cpu_addr` in XLEN: CPU byte address
- `cpu_wdata` in XLEN: CPU write data
- `cpu_we` in 1: CPU write strobe
- `cpu_re` in 1: CPU read strobe
- `cpu_be` in XLEN/8: byte enables
- `cpu_rdata` out XLEN: read data to CPU
- `cpu_ready` out 1: access completes this cycle; 0 = CPU stalls
- `mem_addr` out XLEN: address to data memory
- `mem_wdata` out XLEN: write data to data memory
- `mem_be` out XLEN/8: byte enables to data memory
- `mem_we` out 1: data-memory write enable
- `mem_rdata` in XLEN: data-memory read data
- `con_valid` out 1: console byte available
- `con_data` out 8: console byte
- `con_ready` in 1: bench consumes the byte
- `halt` out 1: program has written `tohost`
- `exit_code` out XLEN: value written to `tohost`

## Operation
- Decode: `is_mmio = (cpu_addr[XLEN-1:8] == MMIO_BASE[XLEN-1:8])`.
- Memory path (`!is_mmio`):
  - `mem_addr`, `mem_wdata` and `mem_be` pass through.
  - `mem_we = cpu_we & !halt`.
  - `cpu_rdata = mem_rdata`.
  - `cpu_ready = 1`.
- MMIO path: `mem_we = 0`. Offset is `cpu_addr[7:0]`; word-aligned offsets only.
  - 0x00 `TX`
    - Write with `cpu_be[0]` pushes `cpu_wdata[7:0]`.
    - Read returns 0.
  - 0x04 `STATUS` (read-only)
    - bit0 = full, bit1 = empty, bits[15:8] = occupancy.
    - All other bits 0.
  - 0x08 `CYCLE_LO`
    - Read returns `cycle[31:0]`.
    - The same read latches `cycle[63:32]` into `hi_snap`.
  - 0x0C `CYCLE_HI`
    - Read returns `hi_snap`.
  - 0x10 `TOHOST`
    - Write sets `halt = 1` and `exit_code = cpu_wdata`.
    - Read returns `exit_code`.
  - Any other offset: read returns 0, write ignored, `cpu_ready = 1`.
- TX FIFO:
  - First-word fall-through.
  - `con_valid = !empty`, `con_data = head`.
  - Pop on `con_valid & con_ready`.
- TX backpressure:
  - A TX write is accepted if `!full`, or if a pop happens the same cycle.
  - Otherwise `cpu_ready = 0`; the CPU holds the request until accepted.
- Cycle counter:
  - Increments by 1 every cycle while `!halt`; wraps modulo 2^64.
- After `halt`:
  - All writes (memory, TX, `TOHOST`) are dropped, with `cpu_ready = 1`.
  - `exit_code` keeps the first written value.
  - Reads still work.
  - The FIFO keeps draining to the console.
- Simultaneous `cpu_we & cpu_re`: treated as a write.

## Timing
- Memory path is purely combinational: zero added latency.
- MMIO reads are combinational from registers; data is valid in the same cycle as the strobe.
- MMIO writes take effect at the next `clk` edge.
- A pushed byte appears on `con_valid` the cycle after the push.
- Full-FIFO write stall ends in the cycle `con_ready` pops; the push and pop commit on the same edge.
- `STATUS` reflects state before the current edge.
- Reset values:
  - FIFO empty, so `con_valid = 0`; `con_data` = 0.
  - `cycle = 0`, `hi_snap = 0`, `halt = 0`, `exit_code = 0`.
  - `cpu_ready = 1` when idle.
- Reset mid-stall: the FIFO is flushed, and any pending TX write is lost.

## Structure
- Package `soc_mmio_pkg`:
  - offset localparams `OFF_TX`, `OFF_STATUS`, `OFF_CYCLE_LO`, `OFF_CYCLE_HI`, `OFF_TOHOST`
  - STATUS bit-position constants
- Sub-module `sync_fifo #(WIDTH, DEPTH)`:
  - pointer-based, with an extra wrap bit for full/empty
  - ports: `push`, `pop`, `din`, `dout`, `full`, `empty`, `count`

## Test plan
- Memory pass-through:
  - Write 0xDEADBEEF to 0x100 with `be = 4'b0011`.
  - Required: `mem_we = 1`, `mem_be = 0011`, `cpu_ready = 1`.
  - Read 0x100 → `cpu_rdata` equals `mem_rdata`.
- Console:
  - With `con_ready = 1`, write 'H' then 'i' to `MMIO_BASE + 0x00`.
  - Required: `con_valid` pulses 0x48 then 0x69, one cycle after each push.
- Backpressure:
  - Hold `con_ready = 0`, write 17 bytes with `TX_DEPTH = 16`.
  - Required: `cpu_ready = 0` on the 17th write; `STATUS = 0x1001`.
  - Raise `con_ready` → the stall releases that cycle, and occupancy stays 16.
- Counter snapshot:
  - Force the counter near 2^32.
  - Read `CYCLE_LO` then `CYCLE_HI` across the carry.
  - Required: `HI` equals the value latched at the `LO` read.
- Halt:
  - Write 0x2A to `TOHOST`.
  - Required: `halt = 1`, `exit_code = 0x2A`.
  - A later `TOHOST` write of 5 and a memory write give `exit_code` still 0x2A and `mem_we = 0`.
  - Counter frozen.
- Reset during stall:
  - With FIFO full and a TX write pending, assert `reset` for one cycle.
  - Required: `con_valid = 0`, `STATUS = 0x0002`, `cpu_ready = 1`.

Source files
------------

// File: rtl/soc_mmio_pkg.sv
// Shared constants for the SoC data-side MMIO bridge: the register offsets
// inside the 256-byte window and the bit layout of the STATUS register.
package soc_mmio_pkg;

    localparam logic [7:0] OFF_TX       = 8'h00;
    localparam logic [7:0] OFF_STATUS   = 8'h04;
    localparam logic [7:0] OFF_CYCLE_LO = 8'h08;
    localparam logic [7:0] OFF_CYCLE_HI = 8'h0C;
    localparam logic [7:0] OFF_TOHOST   = 8'h10;

    localparam int STATUS_FULL_BIT  = 0;
    localparam int STATUS_EMPTY_BIT = 1;
    localparam int STATUS_COUNT_LSB = 8;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO. Read/write pointers carry one
// extra wrap bit so that full and empty are told apart without a counter.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        count    = wr_ptr_q - rd_ptr_q;
        do_pop   = pop && !empty;
        // A full FIFO still takes a push when a pop frees the head slot on the same edge.
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
        dout     = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (do_push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= din;
            end
        end
    end

endmodule

// File: rtl/soc_mmio_bridge.sv
// CPU data-port bridge: plain memory pass-through plus a 256-byte MMIO window
// holding a console TX FIFO, a 64-bit cycle counter and the tohost exit register.
module soc_mmio_bridge
    import soc_mmio_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] MMIO_BASE = 32'hFFFF_0000,
    parameter int              TX_DEPTH  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [XLEN-1:0]   cpu_addr,
    input  logic [XLEN-1:0]   cpu_wdata,
    input  logic              cpu_we,
    input  logic              cpu_re,
    input  logic [XLEN/8-1:0] cpu_be,
    output logic [XLEN-1:0]   cpu_rdata,
    output logic              cpu_ready,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_be,
    output logic              mem_we,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              con_valid,
    output logic [7:0]        con_data,
    input  logic              con_ready,
    output logic              halt,
    output logic [XLEN-1:0]   exit_code
);
    localparam int CW = $clog2(TX_DEPTH) + 1;

    logic            is_mmio, rd, tx_wr, tx_pop;
    logic [7:0]      offset;
    logic            tx_full, tx_empty;
    logic [CW-1:0]   tx_count;
    logic [XLEN-1:0] status;

    logic [63:0]     cycle_q, cycle_d;
    logic [31:0]     hi_snap_q, hi_snap_d;
    logic            halt_q, halt_d;
    logic [XLEN-1:0] exit_code_q, exit_code_d;

    always_comb begin
        is_mmio = (cpu_addr[XLEN-1:8] == MMIO_BASE[XLEN-1:8]);
        offset  = cpu_addr[7:0];
        // A strobe with both we and re set is a write.
        rd      = cpu_re && !cpu_we;
        tx_wr   = is_mmio && (offset == OFF_TX) && cpu_we && cpu_be[0] && !halt_q;
        tx_pop  = !tx_empty && con_ready;

        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_be    = cpu_be;
        mem_we    = !is_mmio && cpu_we && !halt_q;
        cpu_ready = !(tx_wr && tx_full && !tx_pop);

        status                               = '0;
        status[STATUS_FULL_BIT]              = tx_full;
        status[STATUS_EMPTY_BIT]             = tx_empty;
        status[STATUS_COUNT_LSB +: 8]        = 8'(tx_count);

        cpu_rdata = mem_rdata;
        if (is_mmio) begin
            case (offset)
                OFF_STATUS:   cpu_rdata = status;
                OFF_CYCLE_LO: cpu_rdata = XLEN'(cycle_q[31:0]);
                OFF_CYCLE_HI: cpu_rdata = XLEN'(hi_snap_q);
                OFF_TOHOST:   cpu_rdata = exit_code_q;
                default:      cpu_rdata = '0;
            endcase
        end

        cycle_d   = halt_q ? cycle_q : cycle_q + 64'd1;
        // The high half is frozen at the LO read so a LO/HI pair never tears across a carry.
        hi_snap_d = (is_mmio && rd && offset == OFF_CYCLE_LO) ? cycle_q[63:32] : hi_snap_q;

        halt_d      = halt_q;
        exit_code_d = exit_code_q;
        if (is_mmio && cpu_we && offset == OFF_TOHOST && !halt_q) begin
            halt_d      = 1'b1;
            exit_code_d = cpu_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_q     <= '0;
            hi_snap_q   <= '0;
            halt_q      <= 1'b0;
            exit_code_q <= '0;
        end else begin
            cycle_q     <= cycle_d;
            hi_snap_q   <= hi_snap_d;
            halt_q      <= halt_d;
            exit_code_q <= exit_code_d;
        end
    end

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_wr),
        .pop   (tx_pop),
        .din   (cpu_wdata[7:0]),
        .dout  (con_data),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    assign con_valid = !tx_empty;
    assign halt      = halt_q;
    assign exit_code = exit_code_q;

endmodule

// File: tb/tb_soc_mmio_bridge.sv
// Bench for soc_mmio_bridge: a queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized traffic phase.
module tb_soc_mmio_bridge;
    localparam int          XLEN      = 32;
    localparam logic [31:0] MMIO_BASE = 32'hFFFF_0000;
    localparam int          TX_DEPTH  = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_we, cpu_re, cpu_ready;
    logic [3:0]  cpu_be, mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;
    logic        con_valid, con_ready;
    logic [7:0]  con_data;
    logic        halt;
    logic [31:0] exit_code;

    soc_mmio_bridge #(.XLEN(XLEN), .MMIO_BASE(MMIO_BASE), .TX_DEPTH(TX_DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_we    (cpu_we),
        .cpu_re    (cpu_re),
        .cpu_be    (cpu_be),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .con_valid (con_valid),
        .con_data  (con_data),
        .con_ready (con_ready),
        .halt      (halt),
        .exit_code (exit_code)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model state: console bytes as a queue, plain integers for the rest.
    logic [7:0]  m_q[$];
    logic [63:0] m_cycle = '0;
    logic [31:0] m_hi = '0;
    logic        m_halt = 1'b0;
    logic [31:0] m_exit = '0;
    bit          run_model = 0;

    logic        e_mmio, e_full, e_pop, e_txwr, e_halt_old;
    logic [7:0]  e_off;
    logic [31:0] e_rd;

    always @(negedge clk) begin
        if (run_model) begin
            e_mmio = (cpu_addr[31:8] == MMIO_BASE[31:8]);
            e_off  = cpu_addr[7:0];
            e_full = (m_q.size() == TX_DEPTH);
            e_pop  = (m_q.size() != 0) && con_ready;
            e_txwr = e_mmio && e_off == 8'h00 && cpu_we && cpu_be[0] && !m_halt;

            chk("cpu_ready", cpu_ready, !(e_txwr && e_full && !e_pop));
            chk("con_valid", con_valid, m_q.size() != 0);
            chk("con_data", con_data, (m_q.size() != 0) ? m_q[0] : 8'h00);
            chk("halt", halt, m_halt);
            chk("exit_code", exit_code, m_exit);
            chk("mem_we", mem_we, !e_mmio && cpu_we && !m_halt);
            if (!e_mmio) begin
                chk("mem_addr", mem_addr, cpu_addr);
                chk("mem_wdata", mem_wdata, cpu_wdata);
                chk("mem_be", mem_be, cpu_be);
            end
            if (cpu_re && !cpu_we) begin
                if (!e_mmio) e_rd = mem_rdata;
                else begin
                    case (e_off)
                        8'h04:   e_rd = {16'h0, 8'(m_q.size()), 6'h0, m_q.size() == 0, e_full};
                        8'h08:   e_rd = m_cycle[31:0];
                        8'h0C:   e_rd = m_hi;
                        8'h10:   e_rd = m_exit;
                        default: e_rd = 32'h0;
                    endcase
                end
                chk("cpu_rdata", cpu_rdata, e_rd);
            end

            if (reset) begin
                m_q.delete();
                m_cycle = '0;
                m_hi    = '0;
                m_halt  = 1'b0;
                m_exit  = '0;
            end else begin
                e_halt_old = m_halt;
                if (e_mmio && cpu_re && !cpu_we && e_off == 8'h08) m_hi = m_cycle[63:32];
                if (e_pop) void'(m_q.pop_front());
                if (e_txwr && (!e_full || e_pop)) m_q.push_back(cpu_wdata[7:0]);
                if (e_mmio && cpu_we && e_off == 8'h10 && !m_halt) begin
                    m_halt = 1'b1;
                    m_exit = cpu_wdata;
                end
                if (!e_halt_old) m_cycle = m_cycle + 64'd1;
            end
        end
    end

    task automatic set_bus(input logic [31:0] a, input logic [31:0] d, input logic we,
                           input logic re, input logic [3:0] be);
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_we    = we;
        cpu_re    = re;
        cpu_be    = be;
    endtask

    task automatic idle();
        set_bus(32'h0, 32'h0, 1'b0, 1'b0, 4'h0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        mem_rdata = $urandom;
    endtask

    task automatic at_mid();
        @(negedge clk);
        #1;
    endtask

    logic [31:0] r_a, r_d;
    logic        r_we, r_re;
    logic [3:0]  r_be;
    int          k;
    bit          stalled;

    initial begin
        mem_rdata = 32'h0;
        con_ready = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        run_model = 1;

        // Reset values, and STATUS straight out of reset.
        step();
        reset = 1'b0;
        set_bus(MMIO_BASE + 32'h4, 32'h0, 1'b0, 1'b1, 4'h0);
        at_mid();
        chk("rst con_valid", con_valid, 1'b0);
        chk("rst con_data", con_data, 8'h00);
        chk("rst halt", halt, 1'b0);
        chk("rst exit_code", exit_code, 32'h0);
        chk("rst cpu_ready", cpu_ready, 1'b1);
        chk("rst status", cpu_rdata, 32'h0000_0002);

        // Memory pass-through.
        step();
        set_bus(32'h100, 32'hDEAD_BEEF, 1'b1, 1'b0, 4'b0011);
        at_mid();
        chk("mem wr we", mem_we, 1'b1);
        chk("mem wr be", mem_be, 4'b0011);
        chk("mem wr data", mem_wdata, 32'hDEAD_BEEF);
        chk("mem wr ready", cpu_ready, 1'b1);
        step();
        set_bus(32'h100, 32'h0, 1'b0, 1'b1, 4'hF);
        mem_rdata = 32'h1234_5678;
        at_mid();
        chk("mem rd data", cpu_rdata, 32'h1234_5678);

        // Console "Hi".
        step();
        con_ready = 1'b1;
        set_bus(MMIO_BASE, 32'h48, 1'b1, 1'b0, 4'h1);
        at_mid();
        chk("con before push", con_valid, 1'b0);
        step();
        set_bus(MMIO_BASE, 32'h69, 1'b1, 1'b0, 4'h1);
        at_mid();
        chk("con H valid", con_valid, 1'b1);
        chk("con H data", con_data, 8'h48);
        step();
        idle();
        at_mid();
        chk("con i valid", con_valid, 1'b1);
        chk("con i data", con_data, 8'h69);
        step();
        at_mid();
        chk("con drained", con_valid, 1'b0);

        // Backpressure: fill 16 entries, then stall on the 17th.
        step();
        con_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            set_bus(MMIO_BASE, 32'h41 + 32'(i), 1'b1, 1'b0, 4'h1);
            step();
        end
        set_bus(MMIO_BASE + 32'h4, 32'h0, 1'b0, 1'b1, 4'h0);
        at_mid();
        chk("status full", cpu_rdata, 32'h0000_1001);
        step();
        set_bus(MMIO_BASE, 32'h5A, 1'b1, 1'b0, 4'h1);
        at_mid();
        chk("17th write stalls", cpu_ready, 1'b0);
        step();
        at_mid();
        chk("stall held", cpu_ready, 1'b0);
        step();
        con_ready = 1'b1;
        at_mid();
        chk("stall release", cpu_ready, 1'b1);
        chk("head at release", con_data, 8'h41);
        step();
        con_ready = 1'b0;
        set_bus(MMIO_BASE + 32'h4, 32'h0, 1'b0, 1'b1, 4'h0);
        at_mid();
        chk("status after swap", cpu_rdata, 32'h0000_1001);

        // Reset while a TX write is stalled.
        step();
        set_bus(MMIO_BASE, 32'h77, 1'b1, 1'b0, 4'h1);
        at_mid();
        chk("pre-reset stall", cpu_ready, 1'b0);
        step();
        reset = 1'b1;
        at_mid();
        step();
        reset = 1'b0;
        set_bus(MMIO_BASE + 32'h4, 32'h0, 1'b0, 1'b1, 4'h0);
        at_mid();
        chk("post-reset con_valid", con_valid, 1'b0);
        chk("post-reset status", cpu_rdata, 32'h0000_0002);
        chk("post-reset ready", cpu_ready, 1'b1);

        // Randomized traffic; a stalled TX write is held until accepted.
        step();
        stalled = 0;
        for (int n = 0; n < 600; n++) begin
            if (!stalled) begin
                k    = $urandom_range(0, 9);
                r_a  = 32'h0;
                r_d  = $urandom;
                r_we = 1'($urandom_range(0, 1));
                r_re = 1'($urandom_range(0, 1));
                r_be = 4'($urandom_range(0, 15));
                case (k)
                    0, 1, 2: r_a = {1'b0, 31'($urandom)} & 32'hFFFF_FFFC;
                    3, 4, 5: begin r_a = MMIO_BASE; r_we = 1'b1; end
                    6: begin
                        r_a  = MMIO_BASE + (($urandom_range(0, 1) != 0) ? 32'h4 : 32'h10);
                        r_we = 1'b0;
                        r_re = 1'b1;
                    end
                    7: begin r_a = MMIO_BASE + 32'h8; r_we = 1'b0; r_re = 1'b1; end
                    8: begin r_a = MMIO_BASE + 32'hC; r_we = 1'b0; r_re = 1'b1; end
                    default: r_a = MMIO_BASE + 32'($urandom_range(5, 63) * 4);
                endcase
                set_bus(r_a, r_d, r_we, r_re, r_be);
            end
            con_ready = ($urandom_range(0, 2) == 0);
            at_mid();
            stalled = !cpu_ready;
            step();
        end
        idle();
        con_ready = 1'b1;
        repeat (20) step();

        // Cycle counter snapshot across the 2^32 carry.
        force dut.cycle_q = 64'h0000_0000_FFFF_FFFF;
        m_cycle = 64'h0000_0000_FFFF_FFFF;
        #1;
        release dut.cycle_q;
        set_bus(MMIO_BASE + 32'h8, 32'h0, 1'b0, 1'b1, 4'h0);
        at_mid();
        chk("cycle lo pre-carry", cpu_rdata, 32'hFFFF_FFFF);
        step();
        set_bus(MMIO_BASE + 32'hC, 32'h0, 1'b0, 1'b1, 4'h0);
        at_mid();
        chk("cycle hi snap", cpu_rdata, 32'h0);
        step();
        set_bus(MMIO_BASE + 32'h8, 32'h0, 1'b0, 1'b1, 4'h0);
        at_mid();
        chk("cycle lo post-carry", cpu_rdata, 32'h1);
        step();
        set_bus(MMIO_BASE + 32'hC, 32'h0, 1'b0, 1'b1, 4'h0);
        at_mid();
        chk("cycle hi post-carry", cpu_rdata, 32'h1);

        // Halt via tohost; later writes dropped, counter frozen.
        step();
        set_bus(MMIO_BASE + 32'h10, 32'h2A, 1'b1, 1'b0, 4'hF);
        at_mid();
        chk("halt before edge", halt, 1'b0);
        step();
        set_bus(MMIO_BASE + 32'h10, 32'h5, 1'b1, 1'b0, 4'hF);
        at_mid();
        chk("halt set", halt, 1'b1);
        chk("exit code", exit_code, 32'h2A);
        step();
        set_bus(32'h200, 32'hCAFE, 1'b1, 1'b0, 4'hF);
        at_mid();
        chk("halted mem_we", mem_we, 1'b0);
        chk("halted ready", cpu_ready, 1'b1);
        chk("exit code kept", exit_code, 32'h2A);
        step();
        set_bus(MMIO_BASE + 32'h8, 32'h0, 1'b0, 1'b1, 4'h0);
        at_mid();
        chk("frozen cycle lo", cpu_rdata, 32'h4);
        step();
        set_bus(MMIO_BASE + 32'h8, 32'h0, 1'b0, 1'b1, 4'h0);
        at_mid();
        chk("frozen cycle lo again", cpu_rdata, 32'h4);
        step();
        set_bus(MMIO_BASE, 32'h5A, 1'b1, 1'b0, 4'h1);
        at_mid();
        step();
        idle();
        at_mid();
        chk("halted tx dropped", con_valid, 1'b0);
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
